// File: rtl/jtag_scan_pkg.sv
// Shared types, sequence constants and TMS/TDI pattern helpers for the JTAG scan controller.
package jtag_scan_pkg;

    typedef enum logic [1:0] {
        OP_TAP_RESET   = 2'd0,
        OP_IR_SCAN     = 2'd1,
        OP_DR_SCAN     = 2'd2,
        OP_IDLE_CYCLES = 2'd3
    } cmd_op_e;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_PRE,
        ST_SHIFT,
        ST_POST,
        ST_RESP
    } state_e;

    localparam int MAX_LEN   = 32;
    localparam int PRE_IR    = 4;
    localparam int PRE_DR    = 3;
    localparam int POST      = 2;
    localparam int RESET_LEN = 6;

    function automatic logic [5:0] clamp_len(input logic [5:0] len);
        if (len == 6'd0)
            return 6'd1;
        if (len > 6'(MAX_LEN))
            return 6'(MAX_LEN);
        return len;
    endfunction

    function automatic logic [5:0] pre_len(input cmd_op_e op);
        case (op)
            OP_TAP_RESET: return 6'(RESET_LEN);
            OP_IR_SCAN:   return 6'(PRE_IR);
            default:      return 6'(PRE_DR);
        endcase
    endfunction

    // TMS values of the PRE segment, bit k driven during TCK cycle k.
    function automatic logic [7:0] pre_tms(input cmd_op_e op);
        case (op)
            OP_TAP_RESET: return 8'b0001_1111;
            OP_IR_SCAN:   return 8'b0000_0011;
            default:      return 8'b0000_0001;
        endcase
    endfunction

    // {tms, tdi} to present during bit idx of segment st.
    function automatic logic [1:0] pin_bits(input state_e st, input cmd_op_e op, input logic [5:0] idx,
                                            input logic [5:0] len, input logic [31:0] data);
        logic       tms;
        logic       tdi;
        logic [7:0] pat;
        tms = 1'b0;
        tdi = 1'b0;
        pat = pre_tms(op);
        case (st)
            ST_PRE:   tms = pat[idx[2:0]];
            ST_SHIFT: begin
                if (op != OP_IDLE_CYCLES) begin
                    tms = (idx == len - 6'd1);
                    tdi = data[idx[4:0]];
                end
            end
            ST_POST:  tms = (idx == 6'd0);
            default:  ;
        endcase
        return {tms, tdi};
    endfunction

endpackage

// File: rtl/jtag_tck_gen.sv
// TCK divider: each TCK phase lasts CLK_DIV clk_in cycles; TCK is held low while disabled.
module jtag_tck_gen #(
    parameter int CLK_DIV = 4
) (
    input  logic clk_in,
    input  logic reset,
    input  logic enable,
    output logic tck,
    output logic rise_pulse,
    output logic fall_pulse
);

    localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    logic [CW-1:0] div_cnt;
    logic          phase_end;

    // NOTE: pulses are high in the cycle before tck toggles, so users act on the same clk_in edge as the TCK edge.
    assign phase_end  = enable && (div_cnt == CW'(CLK_DIV - 1));
    assign rise_pulse = phase_end && !tck;
    assign fall_pulse = phase_end && tck;

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk_in or posedge reset) begin
        if (reset) begin
            div_cnt <= '0;
            tck     <= 1'b0;
        end else if (!enable) begin
            div_cnt <= '0;
            tck     <= 1'b0;
        end else if (phase_end) begin
            div_cnt <= '0;
            tck     <= ~tck;
        end else begin
            div_cnt <= div_cnt + CW'(1);
        end
    end

endmodule

// File: rtl/jtag_scan_ctrl.sv
// JTAG scan controller: command/response channels driving TAP_RESET, IR/DR scans and idle cycles.
// Optional macro JTAG_SCAN_CTRL_TRST_EN adds a TRST pulse to TAP_RESET.
module jtag_scan_ctrl
    import jtag_scan_pkg::*;
#(
    parameter int CLK_DIV = 4
) (
    input  logic        clk_in,
    input  logic        reset,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [1:0]  cmd_op,
    input  logic [5:0]  cmd_len,
    input  logic [31:0] cmd_data,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_data,
    output logic        rsp_err,
    output logic        jtag_tck,
    output logic        jtag_tms,
    output logic        jtag_tdi,
    output logic        jtag_trst,
    input  logic        jtag_tdo,
    output logic        busy
);

    state_e      state_q, state_d;
    cmd_op_e     op_q;
    cmd_op_e     cmd_op_in;
    logic [5:0]  len_q;
    logic [5:0]  len_eff;
    logic [31:0] data_q;
    logic [5:0]  bit_cnt;
    logic [5:0]  next_idx;
    logic [5:0]  seg_len;
    logic [31:0] cap_q;
    logic        tap_synced;
    logic        tck_en, tck_rise, tck_fall;
    logic        cmd_fire, seg_last, seg_done;

    assign cmd_op_in = cmd_op_e'(cmd_op);
    assign len_eff   = clamp_len(cmd_len);
    assign cmd_fire  = cmd_valid && cmd_ready;

    jtag_tck_gen #(
        .CLK_DIV(CLK_DIV)
    ) u_tck_gen (
        .clk_in    (clk_in),
        .reset     (reset),
        .enable    (tck_en),
        .tck       (jtag_tck),
        .rise_pulse(tck_rise),
        .fall_pulse(tck_fall)
    );

    always_comb begin
        seg_len = 6'd1;
        case (state_q)
            ST_PRE:   seg_len = pre_len(op_q);
            ST_SHIFT: seg_len = len_q;
            ST_POST:  seg_len = 6'(POST);
            default:  ;
        endcase
        seg_last = (bit_cnt == seg_len - 6'd1);
        seg_done = tck_fall && seg_last;
        next_idx = seg_last ? 6'd0 : bit_cnt + 6'd1;
    end

    always_ff @(posedge clk_in or posedge reset) begin
        if (reset)
            state_q <= ST_IDLE;
        else
            state_q <= state_d;
    end

    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    always_comb begin
        state_d   = state_q;
        cmd_ready = 1'b0;
        rsp_valid = 1'b0;
        tck_en    = 1'b0;
        busy      = (state_q != ST_IDLE);
        unique case (state_q)
            ST_IDLE: begin
                // Held low during reset so nothing is accepted before the first post-reset cycle.
                cmd_ready = !reset;
                if (cmd_valid) begin
                    if (cmd_op_in == OP_TAP_RESET)
                        state_d = ST_PRE;
                    else if (!tap_synced)
                        state_d = ST_RESP;
                    else if (cmd_op_in == OP_IDLE_CYCLES)
                        state_d = ST_SHIFT;
                    else
                        state_d = ST_PRE;
                end
            end
            ST_PRE: begin
                tck_en = 1'b1;
                if (seg_done)
                    state_d = (op_q == OP_TAP_RESET) ? ST_RESP : ST_SHIFT;
            end
            ST_SHIFT: begin
                tck_en = 1'b1;
                if (seg_done)
                    state_d = (op_q == OP_IDLE_CYCLES) ? ST_RESP : ST_POST;
            end
            ST_POST: begin
                tck_en = 1'b1;
                if (seg_done)
                    state_d = ST_RESP;
            end
            ST_RESP: begin
                rsp_valid = 1'b1;
                if (rsp_ready)
                    state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // NOTE: command/data registers are reset as well, so rsp_data is defined straight out of reset.
    always_ff @(posedge clk_in or posedge reset) begin
        if (reset) begin
            op_q       <= OP_TAP_RESET;
            len_q      <= 6'd1;
            data_q     <= '0;
            bit_cnt    <= '0;
            cap_q      <= '0;
            tap_synced <= 1'b0;
            jtag_tms   <= 1'b1;
            jtag_tdi   <= 1'b0;
            rsp_data   <= '0;
            rsp_err    <= 1'b0;
        end else begin
            if (cmd_fire) begin
                op_q     <= cmd_op_in;
                len_q    <= len_eff;
                data_q   <= cmd_data;
                bit_cnt  <= '0;
                cap_q    <= '0;
                rsp_data <= '0;
                // Only an unsynced scan jumps straight to RESP; pins stay untouched then.
                rsp_err  <= (state_d == ST_RESP);
                if (state_d != ST_RESP)
                    {jtag_tms, jtag_tdi} <= pin_bits(state_d, cmd_op_in, 6'd0, len_eff, cmd_data);
            end
            if (tck_rise && state_q == ST_SHIFT && op_q != OP_IDLE_CYCLES)
                cap_q[bit_cnt[4:0]] <= jtag_tdo;
            if (tck_fall) begin
                bit_cnt              <= next_idx;
                {jtag_tms, jtag_tdi} <= pin_bits(state_d, op_q, next_idx, len_q, data_q);
            end
            if (seg_done && state_d == ST_RESP) begin
                rsp_data <= (op_q == OP_IR_SCAN || op_q == OP_DR_SCAN) ? cap_q : '0;
                if (op_q == OP_TAP_RESET)
                    tap_synced <= 1'b1;
            end
        end
    end

`ifdef JTAG_SCAN_CTRL_TRST_EN
    logic trst_q;

    // TRST low for the first two TCK cycles of TAP_RESET, released as the third low phase starts.
    always_ff @(posedge clk_in or posedge reset) begin
        if (reset)
            trst_q <= 1'b1;
        else if (cmd_fire && cmd_op_in == OP_TAP_RESET)
            trst_q <= 1'b0;
        else if (tck_fall && state_q == ST_PRE && op_q == OP_TAP_RESET && bit_cnt == 6'd1)
            trst_q <= 1'b1;
    end

    assign jtag_trst = trst_q;
`else
    assign jtag_trst = 1'b1;
`endif

endmodule

// File: tb/tb_jtag_scan_ctrl.sv
// Randomized bench for jtag_scan_ctrl against a pin-level TAP model and an arithmetic scan reference.
module tb_jtag_scan_ctrl;

    localparam int          CLK_DIV    = 3;
    localparam logic [31:0] IDCODE     = 32'h2495_11C3;
    localparam logic [4:0]  IR_IDCODE  = 5'b00001;
    localparam logic [4:0]  IR_BYPASS  = 5'b11111;
    localparam logic [4:0]  IR_CAPTURE = 5'b00001;
    localparam logic [1:0]  OP_RST = 2'd0, OP_IR = 2'd1, OP_DR = 2'd2, OP_IDL = 2'd3;

    logic        clk_in = 1'b0;
    logic        reset  = 1'b1;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [1:0]  cmd_op = 2'd0;
    logic [5:0]  cmd_len = 6'd0;
    logic [31:0] cmd_data = 32'd0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic [31:0] rsp_data;
    logic        rsp_err;
    logic        jtag_tck, jtag_tms, jtag_tdi, jtag_trst;
    logic        jtag_tdo;
    logic        busy;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk_in = ~clk_in;

    jtag_scan_ctrl #(
        .CLK_DIV(CLK_DIV)
    ) dut (
        .clk_in   (clk_in),
        .reset    (reset),
        .cmd_valid(cmd_valid),
        .cmd_ready(cmd_ready),
        .cmd_op   (cmd_op),
        .cmd_len  (cmd_len),
        .cmd_data (cmd_data),
        .rsp_valid(rsp_valid),
        .rsp_ready(rsp_ready),
        .rsp_data (rsp_data),
        .rsp_err  (rsp_err),
        .jtag_tck (jtag_tck),
        .jtag_tms (jtag_tms),
        .jtag_tdi (jtag_tdi),
        .jtag_trst(jtag_trst),
        .jtag_tdo (jtag_tdo),
        .busy     (busy)
    );

    // Pin-level TAP: 5-bit IR, IDCODE and BYPASS data registers.
    typedef enum logic [3:0] {
        T_TLR, T_RTI, T_SDR, T_CDR, T_SHDR, T_E1DR, T_PDR, T_E2DR, T_UDR,
        T_SIR, T_CIR, T_SHIR, T_E1IR, T_PIR, T_E2IR, T_UIR
    } tap_e;

    tap_e        tap_st = T_TLR;
    logic [4:0]  tap_ir = IR_IDCODE;
    logic [4:0]  ir_sr  = 5'd0;
    logic [31:0] dr_sr  = 32'd0;
    logic        tdo_q  = 1'b0;

    assign jtag_tdo = tdo_q;

    function automatic tap_e tap_next(input tap_e s, input logic tms);
        case (s)
            T_TLR:   return tms ? T_TLR  : T_RTI;
            T_RTI:   return tms ? T_SDR  : T_RTI;
            T_SDR:   return tms ? T_SIR  : T_CDR;
            T_CDR:   return tms ? T_E1DR : T_SHDR;
            T_SHDR:  return tms ? T_E1DR : T_SHDR;
            T_E1DR:  return tms ? T_UDR  : T_PDR;
            T_PDR:   return tms ? T_E2DR : T_PDR;
            T_E2DR:  return tms ? T_UDR  : T_SHDR;
            T_UDR:   return tms ? T_SDR  : T_RTI;
            T_SIR:   return tms ? T_TLR  : T_CIR;
            T_CIR:   return tms ? T_E1IR : T_SHIR;
            T_SHIR:  return tms ? T_E1IR : T_SHIR;
            T_E1IR:  return tms ? T_UIR  : T_PIR;
            T_PIR:   return tms ? T_E2IR : T_PIR;
            T_E2IR:  return tms ? T_UIR  : T_SHIR;
            default: return tms ? T_SDR  : T_RTI;
        endcase
    endfunction

    always @(posedge jtag_tck or negedge jtag_trst) begin
        if (!jtag_trst) begin
            tap_st <= T_TLR;
            tap_ir <= IR_IDCODE;
        end else begin
            case (tap_st)
                T_TLR:  tap_ir <= IR_IDCODE;
                T_CIR:  ir_sr  <= IR_CAPTURE;
                T_SHIR: ir_sr  <= {jtag_tdi, ir_sr[4:1]};
                T_UIR:  tap_ir <= ir_sr;
                T_CDR:  dr_sr  <= (tap_ir == IR_IDCODE) ? IDCODE : 32'd0;
                T_SHDR: begin
                    if (tap_ir == IR_IDCODE)
                        dr_sr <= {jtag_tdi, dr_sr[31:1]};
                    else
                        dr_sr[0] <= jtag_tdi;
                end
                default: ;
            endcase
            tap_st <= tap_next(tap_st, jtag_tms);
        end
    end

    always @(negedge jtag_tck)
        tdo_q <= (tap_st == T_SHIR) ? ir_sr[0] : (tap_st == T_SHDR) ? dr_sr[0] : 1'b0;

    // Log of TMS/TDI as seen by the TAP at every TCK rising edge.
    int   rise_cnt = 0;
    logic tms_log [0:4095];
    logic tdi_log [0:4095];

    always @(posedge jtag_tck) begin
        tms_log[rise_cnt % 4096] <= jtag_tms;
        tdi_log[rise_cnt % 4096] <= jtag_tdi;
        rise_cnt <= rise_cnt + 1;
    end

    // Reference knowledge of the target, kept at command level.
    logic       ref_synced = 1'b0;
    logic [4:0] ref_ir     = IR_IDCODE;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_tck"},       64'(jtag_tck),  64'd0);
        check({tag, "_tms"},       64'(jtag_tms),  64'd1);
        check({tag, "_tdi"},       64'(jtag_tdi),  64'd0);
        check({tag, "_trst"},      64'(jtag_trst), 64'd1);
        check({tag, "_cmd_ready"}, 64'(cmd_ready), 64'd0);
        check({tag, "_rsp_valid"}, 64'(rsp_valid), 64'd0);
        check({tag, "_rsp_data"},  64'(rsp_data),  64'd0);
        check({tag, "_rsp_err"},   64'(rsp_err),   64'd0);
        check({tag, "_busy"},      64'(busy),      64'd0);
    endtask

    task automatic send_cmd(input logic [1:0] op, input logic [5:0] len, input logic [31:0] data);
        int t;
        @(negedge clk_in);
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_len   = len;
        cmd_data  = data;
        t = 0;
        while (!cmd_ready && t < 50) begin
            @(negedge clk_in);
            t++;
        end
        check("cmd_ready_wait", 64'(cmd_ready), 64'd1);
        @(negedge clk_in);
        cmd_valid = 1'b0;
    endtask

    task automatic do_cmd(input logic [1:0] op, input logic [5:0] len, input logic [31:0] data, input int delay);
        int          n, cyc, w, mark, got, t;
        logic [63:0] e_tms, e_tdi, g_tms, g_tdi;
        logic [31:0] e_data, cap;
        logic        e_err;
        string       pfx;

        pfx    = $sformatf("op%0d_len%0d", op, len);
        n      = (len == 6'd0) ? 1 : (len > 6'd32) ? 32 : int'(len);
        e_tms  = '0;
        e_tdi  = '0;
        e_data = '0;
        e_err  = 1'b0;
        cyc    = 0;
        if (op != OP_RST && !ref_synced) begin
            e_err = 1'b1;
        end else begin
            case (op)
                OP_RST: begin
                    e_tms = 64'h1F;
                    cyc   = 6;
                end
                OP_IR, OP_DR: begin
                    if (op == OP_IR) begin
                        e_tms = 64'h3;
                        cyc   = 4;
                    end else begin
                        e_tms = 64'h1;
                        cyc   = 3;
                    end
                    for (int i = 0; i < n; i++) begin
                        e_tdi[cyc] = data[i];
                        e_tms[cyc] = (i == n - 1);
                        cyc++;
                    end
                    e_tms[cyc] = 1'b1;
                    cyc += 2;
                    w   = (op == OP_IR) ? 5 : (ref_ir == IR_IDCODE) ? 32 : 1;
                    cap = (op == OP_IR) ? 32'(IR_CAPTURE) : (ref_ir == IR_IDCODE) ? IDCODE : 32'd0;
                    for (int i = 0; i < n; i++)
                        e_data[i] = (i < w) ? cap[i] : data[i - w];
                    if (op == OP_IR)
                        for (int j = 0; j < 5; j++)
                            ref_ir[j] = (j + n < 5) ? cap[j + n] : data[j + n - 5];
                end
                default: cyc = n;
            endcase
        end
        if (op == OP_RST) begin
            ref_synced = 1'b1;
            ref_ir     = IR_IDCODE;
        end

        mark = rise_cnt;
        send_cmd(op, len, data);
        t = 0;
        while (!rsp_valid && t < 2000) begin
            @(negedge clk_in);
            t++;
        end
        check({pfx, "_rsp_valid"}, 64'(rsp_valid), 64'd1);
        if (!rsp_valid)
            return;
        check({pfx, "_rsp_data"}, 64'(rsp_data), 64'(e_data));
        check({pfx, "_rsp_err"},  64'(rsp_err),  64'(e_err));
        for (int d = 0; d < delay; d++) begin
            @(negedge clk_in);
            check({pfx, "_hold_valid"}, 64'(rsp_valid), 64'd1);
            check({pfx, "_hold_data"},  64'(rsp_data),  64'(e_data));
            check({pfx, "_hold_ready"}, 64'(cmd_ready), 64'd0);
        end
        rsp_ready = 1'b1;
        check({pfx, "_no_accept_hs"}, 64'(cmd_ready), 64'd0);
        @(negedge clk_in);
        rsp_ready = 1'b0;
        check({pfx, "_rsp_drop"},   64'(rsp_valid), 64'd0);
        check({pfx, "_idle_ready"}, 64'(cmd_ready), 64'd1);
        check({pfx, "_idle_busy"},  64'(busy),      64'd0);

        got   = rise_cnt - mark;
        g_tms = '0;
        g_tdi = '0;
        for (int k = 0; k < got && k < 64; k++) begin
            g_tms[k] = tms_log[(mark + k) % 4096];
            g_tdi[k] = tdi_log[(mark + k) % 4096];
        end
        check({pfx, "_tck_rises"}, 64'(got), 64'(cyc));
        check({pfx, "_tms_seq"},   g_tms, e_tms);
        check({pfx, "_tdi_seq"},   g_tdi, e_tdi);
        if (ref_synced)
            check({pfx, "_idle_pins"}, {61'd0, jtag_tck, jtag_tms, jtag_tdi}, 64'd0);
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int          r, mark, t;
        logic [1:0]  op;
        logic [5:0]  len;
        logic [31:0] data;

        repeat (3) @(negedge clk_in);
        check_reset_outputs("por");
        reset = 1'b0;
        @(negedge clk_in);
        check("ready_after_reset", 64'(cmd_ready), 64'd1);

        do_cmd(OP_DR, 6'd8, 32'h55, 1);
        do_cmd(OP_RST, 6'd0, 32'd0, 0);
        do_cmd(OP_IR, 6'd5, 32'h01, 0);
        do_cmd(OP_DR, 6'd32, 32'h0, 2);
        do_cmd(OP_IR, 6'd5, 32'h1F, 0);
        do_cmd(OP_DR, 6'd8, 32'hA5, 0);

        for (int it = 0; it < 36; it++) begin
            r = $urandom_range(0, 9);
            if (r == 0) begin
                op  = OP_RST;
                len = 6'($urandom_range(0, 63));
            end else if (r < 4) begin
                op  = OP_IR;
                len = ($urandom_range(0, 3) == 0) ? 6'($urandom_range(0, 63)) : 6'd5;
            end else if (r < 8) begin
                op  = OP_DR;
                len = 6'($urandom_range(0, 63));
            end else begin
                op  = OP_IDL;
                len = 6'($urandom_range(0, 40));
            end
            case ($urandom_range(0, 2))
                0:       data = 32'(IR_IDCODE);
                1:       data = 32'(IR_BYPASS);
                default: data = $urandom;
            endcase
            if (op == OP_DR)
                data = $urandom;
            do_cmd(op, len, data, $urandom_range(0, 3));
        end

        if (!ref_synced)
            do_cmd(OP_RST, 6'd0, 32'd0, 0);
        mark = rise_cnt;
        send_cmd(OP_DR, 6'd32, $urandom);
        t = 0;
        while (rise_cnt - mark < 13 && t < 2000) begin
            @(negedge clk_in);
            t++;
        end
        check("midscan_reached", 64'(rise_cnt - mark >= 13), 64'd1);
        reset = 1'b1;
        #1;
        check_reset_outputs("midscan");
        @(negedge clk_in);
        reset      = 1'b0;
        ref_synced = 1'b0;
        @(negedge clk_in);
        check("ready_after_midscan", 64'(cmd_ready), 64'd1);

        do_cmd(OP_IR, 6'd5, 32'h01, 0);
        do_cmd(OP_IDL, 6'd4, 32'd0, 0);
        do_cmd(OP_RST, 6'd0, 32'd0, 0);
        do_cmd(OP_IDL, 6'd0, 32'd0, 5);
        do_cmd(OP_IDL, 6'd63, 32'd0, 0);
        do_cmd(OP_IR, 6'd5, 32'h01, 0);
        do_cmd(OP_DR, 6'd0, 32'd0, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
